// File: rtl/oled_mode_mux_if.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : oled_mode_mux_if
// Purpose  : Bundles the frame/button inputs, per-source pixel bus and the UI
//            outputs of the OLED source selector.
//   slave  : view taken by oled_mode_mux (inputs: frame_begin, load_done,
//            btn_u/d/l/r/c, src_data; outputs: oled_data, active_src, cursor,
//            app_en, app_btn_u/d, setsel, settings, switch_pend).
//   master : view taken by whatever drives the selector (directions mirrored).
// Revision : 1.0 - initial release
// =============================================================================
interface oled_mode_mux_if #(
  parameter int NUM_SRC = 6,
  parameter int NUM_SET = 3,
  parameter int SET_W   = 2,
  parameter int SRC_W   = $clog2(NUM_SRC)
) ();

  logic                     frame_begin;
  logic                     load_done;
  logic                     btn_u;
  logic                     btn_d;
  logic                     btn_l;
  logic                     btn_r;
  logic                     btn_c;
  logic [16*NUM_SRC-1:0]    src_data;

  logic [15:0]              oled_data;
  logic [SRC_W-1:0]         active_src;
  logic [SRC_W-1:0]         cursor;
  logic [NUM_SRC-1:0]       app_en;
  logic                     app_btn_u;
  logic                     app_btn_d;
  logic [1:0]               setsel;
  logic [NUM_SET*SET_W-1:0] settings;
  logic                     switch_pend;

  modport slave (
    input  frame_begin, load_done, btn_u, btn_d, btn_l, btn_r, btn_c, src_data,
    output oled_data, active_src, cursor, app_en, app_btn_u, app_btn_d,
           setsel, settings, switch_pend
  );

  modport master (
    output frame_begin, load_done, btn_u, btn_d, btn_l, btn_r, btn_c, src_data,
    input  oled_data, active_src, cursor, app_en, app_btn_u, app_btn_d,
           setsel, settings, switch_pend
  );

endinterface
`default_nettype wire

// File: rtl/oled_mode_mux.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : oled_mode_mux
// Purpose  : OLED source selector and UI controller. Sequences loading ->
//            welcome -> menu -> application screens from button pulses, keeps
//            per-application settings counters across visits, and swaps the
//            displayed pixel source only on a frame boundary.
// Ports    : CLOCK  - system clock (rising edge)
//            reset  - asynchronous active-low reset
//            bus    - oled_mode_mux_if.slave (buttons, frame_begin, load_done,
//                     src_data in; oled_data, active_src, cursor, app_en,
//                     app_btn_u/d, setsel, settings, switch_pend out)
// Revision : 1.0 - initial release
// =============================================================================
module oled_mode_mux #(
  parameter int NUM_SRC = 6,
  parameter int NUM_SET = 3,
  parameter int SET_W   = 2,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  wire logic      CLOCK,
  input  wire logic      reset,
  oled_mode_mux_if.slave bus
);

  localparam int               c_num_app   = NUM_SRC - 3;
  localparam logic [SRC_W-1:0] c_src_load  = SRC_W'(0);
  localparam logic [SRC_W-1:0] c_src_wel   = SRC_W'(1);
  localparam logic [SRC_W-1:0] c_src_menu  = SRC_W'(2);
  localparam logic [SRC_W-1:0] c_first_app = SRC_W'(3);
  localparam logic [SRC_W-1:0] c_last_app  = SRC_W'(NUM_SRC - 1);
  localparam logic [1:0]       c_last_set  = 2'(NUM_SET - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_WELCOME = 2'd1,
    S_MENU    = 2'd2,
    S_APP     = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SRC_W-1:0]   r_req_src, w_req_nxt;
  logic [SRC_W-1:0]   r_active_src;
  logic [SRC_W-1:0]   r_cursor, w_cursor_nxt;
  logic [SRC_W-1:0]   r_app, w_app_nxt;
  logic [1:0]         r_setsel, w_setsel_nxt;
  logic               w_set_inc;
  logic [NUM_SRC-1:0] r_app_en, w_app_en_nxt;
  logic               r_app_btn_u, r_app_btn_d;
  logic [SET_W-1:0]   r_settings [c_num_app][NUM_SET];

  logic [NUM_SET*SET_W-1:0] w_settings;
  logic [15:0]              w_oled;

  // Only the highest-priority pulse of a cycle survives: c > l > r > u/d.
  logic w_c, w_l, w_r, w_u, w_d;
  assign w_c = bus.btn_c;
  assign w_l = bus.btn_l & ~bus.btn_c;
  assign w_r = bus.btn_r & ~bus.btn_c & ~bus.btn_l;
  assign w_u = bus.btn_u & ~(bus.btn_c | bus.btn_l | bus.btn_r);
  assign w_d = bus.btn_d & ~(bus.btn_c | bus.btn_l | bus.btn_r);

  // ---------------------------------------------------------------------------
  // Next-state / next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cursor_nxt = r_cursor;
    w_app_nxt    = r_app;
    w_setsel_nxt = r_setsel;
    w_set_inc    = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (bus.load_done) w_state_nxt = S_WELCOME;
      end
      S_WELCOME: begin
        if (w_c) w_state_nxt = S_MENU;
      end
      S_MENU: begin
        if (w_c) begin
          w_app_nxt    = r_cursor;
          w_setsel_nxt = 2'd0;
          w_state_nxt  = S_APP;
        end else if (w_d && !w_u) begin
          w_cursor_nxt = (r_cursor == c_last_app) ? c_first_app : r_cursor + SRC_W'(1);
        end else if (w_u && !w_d) begin
          // Simultaneous up and down cancel out.
          w_cursor_nxt = (r_cursor == c_first_app) ? c_last_app : r_cursor - SRC_W'(1);
        end
      end
      S_APP: begin
        if (w_c) begin
          w_state_nxt = S_MENU;
        end else if (w_l) begin
          w_setsel_nxt = (r_setsel == c_last_set) ? 2'd0 : r_setsel + 2'd1;
        end else if (w_r) begin
          w_set_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    w_req_nxt = c_src_load;
    case (w_state_nxt)
      S_LOAD:    w_req_nxt = c_src_load;
      S_WELCOME: w_req_nxt = c_src_wel;
      S_MENU:    w_req_nxt = c_src_menu;
      S_APP:     w_req_nxt = w_app_nxt;
      default:   w_req_nxt = c_src_load;
    endcase
  end

  always_comb begin
    w_app_en_nxt = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_app_en_nxt[k] = (w_state_nxt == S_APP) && (w_app_nxt == SRC_W'(k));
    end
  end

  // ---------------------------------------------------------------------------
  // State and UI registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      r_state      <= S_LOAD;
      r_req_src    <= c_src_load;
      r_active_src <= c_src_load;
      r_cursor     <= c_first_app;
      r_app        <= c_first_app;
      r_setsel     <= 2'd0;
      r_app_en     <= '0;
      r_app_btn_u  <= 1'b0;
      r_app_btn_d  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_src   <= w_req_nxt;
      r_cursor    <= w_cursor_nxt;
      r_app       <= w_app_nxt;
      r_setsel    <= w_setsel_nxt;
      r_app_en    <= w_app_en_nxt;
      r_app_btn_u <= (r_state == S_APP) && w_u;
      r_app_btn_d <= (r_state == S_APP) && w_d;
      // Old r_req_src is taken here, so a request made on a frame_begin
      // edge waits for the following frame.
      if (bus.frame_begin) r_active_src <= r_req_src;
    end
  end

  // Settings counters: one bank per application, wrap modulo 2^SET_W.
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < c_num_app; a++) begin
        for (int s = 0; s < NUM_SET; s++) begin
          r_settings[a][s] <= '0;
        end
      end
    end else if (w_set_inc) begin
      for (int a = 0; a < c_num_app; a++) begin
        for (int s = 0; s < NUM_SET; s++) begin
          if ((r_app == SRC_W'(a + 3)) && (r_setsel == 2'(s))) begin
            r_settings[a][s] <= r_settings[a][s] + SET_W'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_settings = '0;
    for (int a = 0; a < c_num_app; a++) begin
      if (r_app == SRC_W'(a + 3)) begin
        for (int s = 0; s < NUM_SET; s++) begin
          w_settings[s*SET_W +: SET_W] = r_settings[a][s];
        end
      end
    end
  end

  always_comb begin
    w_oled = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_active_src == SRC_W'(k)) w_oled = bus.src_data[16*k +: 16];
    end
  end

  assign bus.oled_data   = w_oled;
  assign bus.active_src  = r_active_src;
  assign bus.cursor      = r_cursor;
  assign bus.app_en      = r_app_en;
  assign bus.app_btn_u   = r_app_btn_u;
  assign bus.app_btn_d   = r_app_btn_d;
  assign bus.setsel      = r_setsel;
  assign bus.settings    = w_settings;
  assign bus.switch_pend = (r_req_src != r_active_src);

endmodule
`default_nettype wire

// File: tb/tb_oled_mode_mux.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_oled_mode_mux
// Purpose  : Self-checking bench for oled_mode_mux. Directed scenarios followed
//            by random button/frame traffic; a reference model predicts every
//            cycle's outputs into a queue that a monitor drains and compares.
// Revision : 1.0 - initial release
// =============================================================================
module tb_oled_mode_mux;

  localparam int NUM_SRC = 6;
  localparam int NUM_SET = 3;
  localparam int SET_W   = 2;
  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam int NUM_APP = NUM_SRC - 3;
  localparam int M_LOAD = 0, M_WEL = 1, M_MENU = 2, M_APP = 3;

  logic CLOCK = 1'b0;
  logic reset = 1'b1;
  always #5 CLOCK = ~CLOCK;

  oled_mode_mux_if #(.NUM_SRC(NUM_SRC), .NUM_SET(NUM_SET), .SET_W(SET_W), .SRC_W(SRC_W)) bus ();

  oled_mode_mux #(.NUM_SRC(NUM_SRC), .NUM_SET(NUM_SET), .SET_W(SET_W), .SRC_W(SRC_W)) dut (
    .CLOCK (CLOCK),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0]              oled;
    logic [SRC_W-1:0]         act;
    logic [SRC_W-1:0]         cur;
    logic [NUM_SRC-1:0]       en;
    logic                     bu;
    logic                     bd;
    logic [1:0]               ss;
    logic [NUM_SET*SET_W-1:0] set;
    logic                     pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state (plain integers).
  int m_mode, m_cur, m_app, m_ss, m_act, m_req;
  int m_set [NUM_APP][NUM_SET];
  bit m_bu, m_bd;
  logic                  ld_lvl;
  logic [16*NUM_SRC-1:0] cur_src;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_LOAD; m_cur = 3; m_app = 3; m_ss = 0; m_act = 0; m_req = 0;
    m_bu = 0; m_bd = 0;
    for (int a = 0; a < NUM_APP; a++)
      for (int s = 0; s < NUM_SET; s++) m_set[a][s] = 0;
  endfunction

  function automatic void model_step(input bit rn, ld, fb, u, d, l, r, c);
    bit ud_ok;
    if (!rn) begin
      model_reset();
      return;
    end
    ud_ok = !(c || l || r);
    if (fb) m_act = m_req;
    m_bu = (m_mode == M_APP) && u && ud_ok;
    m_bd = (m_mode == M_APP) && d && ud_ok;
    case (m_mode)
      M_LOAD: if (ld) m_mode = M_WEL;
      M_WEL:  if (c) m_mode = M_MENU;
      M_MENU: begin
        if (c) begin
          m_app = m_cur; m_ss = 0; m_mode = M_APP;
        end else if (ud_ok && (u != d)) begin
          if (d) m_cur = 3 + ((m_cur - 3 + 1) % NUM_APP);
          else   m_cur = 3 + ((m_cur - 3 + NUM_APP - 1) % NUM_APP);
        end
      end
      default: begin
        if (c)      m_mode = M_MENU;
        else if (l) m_ss = (m_ss + 1) % NUM_SET;
        else if (r) m_set[m_app-3][m_ss] = (m_set[m_app-3][m_ss] + 1) % (1 << SET_W);
      end
    endcase
    m_req = (m_mode == M_APP) ? m_app : m_mode;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.oled = cur_src[16*m_act +: 16];
    e.act  = SRC_W'(m_act);
    e.cur  = SRC_W'(m_cur);
    for (int k = 0; k < NUM_SRC; k++) e.en[k] = (m_mode == M_APP) && (m_app == k);
    e.bu   = m_bu;
    e.bd   = m_bd;
    e.ss   = 2'(m_ss);
    for (int s = 0; s < NUM_SET; s++) e.set[s*SET_W +: SET_W] = SET_W'(m_set[m_app-3][s]);
    e.pend = (m_req != m_act);
    return e;
  endfunction

  // Apply one cycle of stimulus at the falling edge and queue the prediction.
  task automatic drive(input bit rn, fb, u, d, l, r, c);
    @(negedge CLOCK);
    for (int k = 0; k < NUM_SRC; k++) cur_src[16*k +: 16] = 16'($urandom);
    reset           = rn;
    bus.load_done   = ld_lvl;
    bus.frame_begin = fb;
    bus.btn_u = u; bus.btn_d = d; bus.btn_l = l; bus.btn_r = r; bus.btn_c = c;
    bus.src_data    = cur_src;
    model_step(rn, ld_lvl, fb, u, d, l, r, c);
    exp_q.push_back(expect_now());
  endtask

  task automatic idle_fb(input int n);
    for (int i = 0; i < n; i++) drive(1, (i == n - 1), 0, 0, 0, 0, 0);
  endtask

  task automatic at_sample();
    @(posedge CLOCK);
    #1;
  endtask

  // Monitor: compares every predicted cycle against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLOCK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("oled_data",   bus.oled_data,   e.oled);
        cmp("active_src",  bus.active_src,  e.act);
        cmp("cursor",      bus.cursor,      e.cur);
        cmp("app_en",      bus.app_en,      e.en);
        cmp("app_btn_u",   bus.app_btn_u,   e.bu);
        cmp("app_btn_d",   bus.app_btn_d,   e.bd);
        cmp("setsel",      bus.setsel,      e.ss);
        cmp("settings",    bus.settings,    e.set);
        cmp("switch_pend", bus.switch_pend, e.pend);
      end
    end
  end

  initial begin
    logic [15:0] slice;
    bus.frame_begin = 0; bus.load_done = 0; bus.src_data = '0;
    bus.btn_u = 0; bus.btn_d = 0; bus.btn_l = 0; bus.btn_r = 0; bus.btn_c = 0;
    ld_lvl = 0; cur_src = '0;
    model_reset();
    #1 reset = 1'b0;

    // Boot: reset hold, buttons ignored while loading, then load_done.
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    repeat (5) drive(1, 0, 1, 1, 1, 1, 0);
    ld_lvl = 1;
    drive(1, 0, 0, 0, 0, 0, 0);
    at_sample();
    cmp("boot_pend",   bus.switch_pend, 1);
    cmp("boot_active", bus.active_src,  0);
    idle_fb(3);
    at_sample();
    cmp("welcome_active", bus.active_src, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    idle_fb(2);

    // Menu wrap.
    drive(1, 0, 0, 1, 0, 0, 0); at_sample(); cmp("wrap_d1", bus.cursor, 4);
    drive(1, 0, 0, 1, 0, 0, 0); at_sample(); cmp("wrap_d2", bus.cursor, 5);
    drive(1, 0, 0, 1, 0, 0, 0); at_sample(); cmp("wrap_d3", bus.cursor, 3);
    drive(1, 0, 1, 0, 0, 0, 0); at_sample(); cmp("wrap_u1", bus.cursor, 5);

    // Settings retention across apps 4 and 5.
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    repeat (5) drive(1, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    repeat (2) drive(1, 0, 0, 0, 0, 1, 0);
    at_sample();
    cmp("ret_settings", bus.settings, 6'h09);
    cmp("ret_setsel",   bus.setsel,   1);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    at_sample();
    cmp("app5_settings", bus.settings, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    at_sample();
    cmp("reenter_settings", bus.settings, 6'h09);
    cmp("reenter_setsel",   bus.setsel,   0);
    idle_fb(2);

    // Tear-free switch: exit coincides with frame_begin.
    drive(1, 1, 0, 0, 0, 0, 1);
    at_sample();
    cmp("tear_active_hold", bus.active_src,  4);
    cmp("tear_pend",        bus.switch_pend, 1);
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
    at_sample();
    cmp("tear_active_wait", bus.active_src, 4);
    drive(1, 1, 0, 0, 0, 0, 0);
    at_sample();
    slice = cur_src[32 +: 16];
    cmp("tear_active_new", bus.active_src, 2);
    cmp("tear_oled",       bus.oled_data,  slice);

    // Priority and forwarding.
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1, 1);
    at_sample();
    cmp("prio_settings", bus.settings, 6'h09);
    cmp("prio_app_en",   bus.app_en,   0);
    drive(1, 0, 1, 0, 0, 0, 0);
    at_sample();
    cmp("menu_no_fwd", bus.app_btn_u, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 0, 0, 0);
    at_sample();
    cmp("app_fwd_u",    bus.app_btn_u,   1);
    cmp("pre_rst_pend", bus.switch_pend, 1);

    // Asynchronous reset mid-cycle, no clock edge before checking.
    #2 reset = 1'b0;
    #1;
    cmp("arst_active",   bus.active_src,  0);
    cmp("arst_cursor",   bus.cursor,      3);
    cmp("arst_app_en",   bus.app_en,      0);
    cmp("arst_btn_u",    bus.app_btn_u,   0);
    cmp("arst_setsel",   bus.setsel,      0);
    cmp("arst_settings", bus.settings,    0);
    cmp("arst_pend",     bus.switch_pend, 0);
    slice = cur_src[15:0];
    cmp("arst_oled",     bus.oled_data,   slice);
    model_reset();
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    at_sample();
    cmp("post_rst_settings", bus.settings, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ld_lvl = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 499) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0));
    end
    idle_fb(2);
    at_sample();
    #1;
    cmp("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
